// File: rtl/nibble_seq_pkg.sv
// Shared types and constants for the nibble sequencer block.
package nibble_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic {IDLE, PLAY} seq_state_t;

endpackage

// File: rtl/nibble_sequencer_if.sv
// Control/data bundle between a stimulus driver and the nibble sequencer.
interface nibble_sequencer_if
    import nibble_seq_pkg::*;
#(
    parameter int unsigned WIDTH = NIBBLE_W,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clear;
    logic             start;
    logic             loop;
    logic             stop;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             busy;
    logic             done;
    logic             full;
    logic [CW-1:0]    count;

    modport master (
        output wr_en, wr_data, clear, start, loop, stop,
        input  d, d_valid, busy, done, full, count
    );

    modport slave (
        input  wr_en, wr_data, clear, start, loop, stop,
        output d, d_valid, busy, done, full, count
    );

endinterface

// File: rtl/hold_timer.sv
// Counts 0..HOLD-1 while run is high; expire marks the final hold cycle.
module hold_timer #(
    parameter int unsigned HOLD = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expire
);
    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero while idle so every run starts a fresh hold period.
    always_comb begin
        cnt_d = '0;
        if (run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign expire = run && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nibble_sequencer.sv
// Buffers up to DEPTH patterns and plays each on d for HOLD cycles, once or looped.
module nibble_sequencer
    import nibble_seq_pkg::*;
#(
    parameter int unsigned WIDTH = NIBBLE_W,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned HOLD  = 10
) (
    input logic               clk,
    input logic               reset,
    nibble_sequencer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] FIRST = '0;

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             d_valid_q, d_valid_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic full, last, wr_accept, expire, playing;

    assign playing = (state_q == PLAY);
    assign full    = (count_q == CW'(DEPTH));
    assign last    = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

    hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (playing),
        .expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        d_d       = d_q;
        d_valid_d = d_valid_q;
        done_d    = 1'b0;
        wr_accept = 1'b0;

        unique case (state_q)
            IDLE: begin
                d_d       = '0;
                d_valid_d = 1'b0;
                if (bus.clear) begin
                    count_d = '0;
                end else if (bus.wr_en && !full) begin
                    wr_accept = 1'b1;
                    count_d   = count_q + CW'(1);
                end
                // A write landing on an empty buffer is itself entry 0.
                if (bus.start && (count_d != '0)) begin
                    state_d   = PLAY;
                    rd_ptr_d  = FIRST;
                    d_d       = (count_q == '0) ? bus.wr_data : mem[FIRST];
                    d_valid_d = 1'b1;
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    state_d   = IDLE;
                    rd_ptr_d  = FIRST;
                    d_d       = '0;
                    d_valid_d = 1'b0;
                end else if (expire) begin
                    if (!last) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        d_d      = mem[rd_ptr_d];
                    end else if (bus.loop) begin
                        rd_ptr_d = FIRST;
                        d_d      = mem[FIRST];
                    end else begin
                        state_d   = IDLE;
                        rd_ptr_d  = FIRST;
                        d_d       = '0;
                        d_valid_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
            done_q    <= done_d;
        end
    end

    // Pattern storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[count_q[PW-1:0]] <= bus.wr_data;
        end
    end

    assign bus.d       = d_q;
    assign bus.d_valid = d_valid_q;
    assign bus.busy    = playing;
    assign bus.done    = done_q;
    assign bus.full    = full;
    assign bus.count   = count_q;

endmodule

// File: tb/tb_nibble_sequencer.sv
// Directed bench for nibble_sequencer: IDLE vector table plus playback sequences.
module tb_nibble_sequencer;

    localparam int unsigned HOLD = 10;

    typedef struct {
        logic       wr_en;
        logic [3:0] wr_data;
        logic       clear;
        logic       start;
        logic [3:0] exp_count;
        logic       exp_full;
        logic       exp_busy;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    logic [3:0] pat [8];
    logic [3:0] inv_q;
    vec_t vecs [14];

    nibble_sequencer_if #(.WIDTH(4), .DEPTH(8)) bus ();

    nibble_sequencer #(
        .WIDTH (4),
        .DEPTH (8),
        .HOLD  (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the downstream inverter.
    assign inv_q = ~bus.d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] val);
        bus.wr_en   = 1'b1;
        bus.wr_data = val;
        cycle();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    // Expects n entries of pat[] back to back, HOLD cycles each, no done.
    task automatic check_pass(input int n);
        logic [3:0] exp_inv;
        for (int e = 0; e < n; e++) begin
            exp_inv = ~pat[e];
            for (int h = 0; h < int'(HOLD); h++) begin
                chk("play d", 32'(bus.d), 32'(pat[e]));
                chk("play inverter", 32'(inv_q), 32'(exp_inv));
                chk("play d_valid", 32'(bus.d_valid), 1);
                chk("play busy", 32'(bus.busy), 1);
                chk("play done", 32'(bus.done), 0);
                cycle();
            end
        end
    endtask

    task automatic chk_done();
        chk("done pulse", 32'(bus.done), 1);
        chk("d at done", 32'(bus.d), 0);
        chk("d_valid at done", 32'(bus.d_valid), 0);
        chk("busy at done", 32'(bus.busy), 0);
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.clear   = 1'b0;
        bus.start   = 1'b0;
        bus.loop    = 1'b0;
        bus.stop    = 1'b0;

        vecs[0]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};  // start on empty
        vecs[1]  = '{1'b1, 4'h1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'h2, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'h3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};  // clear beats write
        for (int i = 0; i < 8; i++) begin
            vecs[4+i] = '{1'b1, 4'(i + 1), 1'b0, 1'b0, 4'(i + 1), (i == 7), 1'b0};
        end
        vecs[12] = '{1'b1, 4'h9, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0};  // dropped when full
        vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("reset d", 32'(bus.d), 0);
        chk("reset d_valid", 32'(bus.d_valid), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset full", 32'(bus.full), 0);
        chk("reset count", 32'(bus.count), 0);
        reset = 1'b0;
        cycle();

        for (int i = 0; i < 14; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_data = vecs[i].wr_data;
            bus.clear   = vecs[i].clear;
            bus.start   = vecs[i].start;
            cycle();
            chk($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d full", i), 32'(bus.full), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d d", i), 32'(bus.d), 0);
        end
        bus.wr_en = 1'b0;
        bus.clear = 1'b0;
        bus.start = 1'b0;

        // Full buffer plays 1..8 only.
        for (int i = 0; i < 8; i++) pat[i] = 4'(i + 1);
        do_start();
        check_pass(8);
        chk_done();
        chk("count after pass", 32'(bus.count), 8);

        // Single pass of six patterns; done lands 60 edges after the start edge.
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        chk("count after clear", 32'(bus.count), 0);
        pat[0] = 4'hF; pat[1] = 4'h0; pat[2] = 4'hC;
        pat[3] = 4'h3; pat[4] = 4'hA; pat[5] = 4'hF;
        for (int i = 0; i < 6; i++) wr(pat[i]);
        do_start();
        check_pass(6);
        chk_done();
        // Back-to-back start on the done cycle.
        do_start();
        chk("b2b busy", 32'(bus.busy), 1);
        chk("b2b d", 32'(bus.d), 32'hF);
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        chk("stop busy", 32'(bus.busy), 0);
        chk("stop done", 32'(bus.done), 0);

        // Looping: three seamless passes, then dropping loop finishes the pass.
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        pat[0] = 4'hA; pat[1] = 4'h5;
        wr(pat[0]);
        wr(pat[1]);
        bus.loop = 1'b1;
        do_start();
        for (int p = 0; p < 3; p++) check_pass(2);
        bus.loop = 1'b0;
        check_pass(2);
        chk_done();

        // Stop mid-hold on entry 2, with writes and clear ignored while playing.
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        pat[0] = 4'h1; pat[1] = 4'h2; pat[2] = 4'h3;
        for (int i = 0; i < 3; i++) wr(pat[i]);
        do_start();
        bus.wr_en   = 1'b1;
        bus.wr_data = 4'h7;
        bus.clear   = 1'b1;
        for (int i = 0; i < 24; i++) begin
            chk("pre-stop d", 32'(bus.d), 32'(pat[i / 10]));
            cycle();
        end
        bus.wr_en = 1'b0;
        bus.clear = 1'b0;
        chk("count during play", 32'(bus.count), 3);
        chk("entry 2 before stop", 32'(bus.d), 32'h3);
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        chk("after stop d", 32'(bus.d), 0);
        chk("after stop busy", 32'(bus.busy), 0);
        chk("after stop d_valid", 32'(bus.d_valid), 0);
        chk("after stop done", 32'(bus.done), 0);
        cycle();
        chk("no late done", 32'(bus.done), 0);
        do_start();
        chk("replay d", 32'(bus.d), 32'h1);
        chk("replay busy", 32'(bus.busy), 1);

        // Asynchronous reset during PLAY.
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        chk("async rst d", 32'(bus.d), 0);
        chk("async rst d_valid", 32'(bus.d_valid), 0);
        chk("async rst busy", 32'(bus.busy), 0);
        chk("async rst count", 32'(bus.count), 0);
        chk("async rst full", 32'(bus.full), 0);
        cycle();
        reset = 1'b0;
        do_start();
        chk("start empty busy", 32'(bus.busy), 0);
        chk("start empty d_valid", 32'(bus.d_valid), 0);

        // Start together with the first write: one-entry playback.
        bus.wr_en   = 1'b1;
        bus.wr_data = 4'h6;
        bus.start   = 1'b1;
        cycle();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        chk("start+wr count", 32'(bus.count), 1);
        pat[0] = 4'h6;
        check_pass(1);
        chk_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
